// File: rtl/cnn_seq_pkg.sv
// Shared constants and FSM encoding for the convolution window address sequencer.
package cnn_seq_pkg;

    localparam int DIMWIDTH_DEF  = 10;
    localparam int KWIDTH_DEF    = 3;
    localparam int ADDRWIDTH_DEF = 20;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        RUN   = ST_RUN,
        DONE  = ST_DONE
    } seq_state_t;

endpackage

// File: rtl/conv_window_sequencer_if.sv
// Controller config/start plus memory address stream of the window sequencer.
interface conv_window_sequencer_if #(
    parameter int DIMWIDTH  = 10,
    parameter int KWIDTH    = 3,
    parameter int ADDRWIDTH = 20
);
    logic                 CONV_WINDOW_SEQ_Start;
    logic [DIMWIDTH-1:0]  CONV_WINDOW_SEQ_Width;
    logic [DIMWIDTH-1:0]  CONV_WINDOW_SEQ_Height;
    logic [KWIDTH-1:0]    CONV_WINDOW_SEQ_Ksize;
    logic [ADDRWIDTH-1:0] CONV_WINDOW_SEQ_Base;
    logic                 CONV_WINDOW_SEQ_Ready;
    logic [ADDRWIDTH-1:0] CONV_WINDOW_SEQ_Addr;
    logic                 CONV_WINDOW_SEQ_Valid;
    logic                 CONV_WINDOW_SEQ_Win_Last;
    logic                 CONV_WINDOW_SEQ_Frame_Last;
    logic                 CONV_WINDOW_SEQ_Busy;
    logic                 CONV_WINDOW_SEQ_Done;
    logic                 CONV_WINDOW_SEQ_Err;

    // master: the sequencer itself; slave: controller + memory side
    modport master (
        input  CONV_WINDOW_SEQ_Start, CONV_WINDOW_SEQ_Width, CONV_WINDOW_SEQ_Height,
        input  CONV_WINDOW_SEQ_Ksize, CONV_WINDOW_SEQ_Base, CONV_WINDOW_SEQ_Ready,
        output CONV_WINDOW_SEQ_Addr, CONV_WINDOW_SEQ_Valid, CONV_WINDOW_SEQ_Win_Last,
        output CONV_WINDOW_SEQ_Frame_Last, CONV_WINDOW_SEQ_Busy, CONV_WINDOW_SEQ_Done,
        output CONV_WINDOW_SEQ_Err
    );

    modport slave (
        output CONV_WINDOW_SEQ_Start, CONV_WINDOW_SEQ_Width, CONV_WINDOW_SEQ_Height,
        output CONV_WINDOW_SEQ_Ksize, CONV_WINDOW_SEQ_Base, CONV_WINDOW_SEQ_Ready,
        input  CONV_WINDOW_SEQ_Addr, CONV_WINDOW_SEQ_Valid, CONV_WINDOW_SEQ_Win_Last,
        input  CONV_WINDOW_SEQ_Frame_Last, CONV_WINDOW_SEQ_Busy, CONV_WINDOW_SEQ_Done,
        input  CONV_WINDOW_SEQ_Err
    );
endinterface

// File: rtl/conv_window_sequencer_wrap_counter.sv
// Wrapping index counter: counts 0..limit on enable, terminal flag when count==limit.
// Latency 1 cycle; no backpressure of its own, the caller gates the enable.
module wrap_counter #(
    parameter int WIDTH = 10
) (
    input  logic             WRAP_CNT_Clk,
    input  logic             WRAP_CNT_Clr,
    input  logic             WRAP_CNT_Load0,
    input  logic             WRAP_CNT_En,
    input  logic [WIDTH-1:0] WRAP_CNT_Limit,
    output logic [WIDTH-1:0] WRAP_CNT_Count,
    output logic             WRAP_CNT_Term
);

    assign WRAP_CNT_Term = (WRAP_CNT_Count == WRAP_CNT_Limit);

    always_ff @(posedge WRAP_CNT_Clk or negedge WRAP_CNT_Clr) begin
        if (!WRAP_CNT_Clr) begin
            WRAP_CNT_Count <= '0;
        end else if (WRAP_CNT_Load0) begin
            WRAP_CNT_Count <= '0;
        end else if (WRAP_CNT_En) begin
            WRAP_CNT_Count <= WRAP_CNT_Term ? '0 : WRAP_CNT_Count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// KxK stride-1 window read-address generator; first Valid 2 cycles after Start, then 1 addr/cycle.
// Valid/ready stream: Addr and flags hold while Ready is low; Done 1 cycle after the final transfer.
module conv_window_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int DIMWIDTH  = DIMWIDTH_DEF,
    parameter int KWIDTH    = KWIDTH_DEF,
    parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
    input  logic                    CONV_WINDOW_SEQ_Clk,
    input  logic                    CONV_WINDOW_SEQ_Clr,
    conv_window_sequencer_if.master seq
);

    seq_state_t state_q, state_d;

    logic [DIMWIDTH-1:0]  w_q, h_q;
    logic [KWIDTH-1:0]    k_q;
    logic                 err_q;
    logic [ADDRWIDTH-1:0] row_start_q, win_base_q, tap_row_q;

    logic [DIMWIDTH-1:0]  k_ext, k_lim, oc_lim, orow_lim;
    logic [ADDRWIDTH-1:0] w_ext;
    logic [DIMWIDTH-1:0]  kc_cnt, kr_cnt, oc_cnt, orow_cnt;
    logic                 kc_term, kr_term, oc_term, orow_term;
    logic                 start_acc, cfg_bad, xfer;
    logic                 wrap_kc, wrap_kr, wrap_oc, last_xfer;
    logic                 valid, busy, done;

    assign k_ext    = DIMWIDTH'(k_q);
    assign k_lim    = k_ext - DIMWIDTH'(1);
    assign oc_lim   = w_q - k_ext;
    assign orow_lim = h_q - k_ext;
    assign w_ext    = ADDRWIDTH'(w_q);

    assign cfg_bad   = (k_q == '0) || (k_ext > w_q) || (k_ext > h_q);
    assign start_acc = (state_q == IDLE) && seq.CONV_WINDOW_SEQ_Start;
    assign xfer      = valid && seq.CONV_WINDOW_SEQ_Ready;

    // Each stage advances only when every faster stage wraps on this transfer.
    assign wrap_kc   = xfer && kc_term;
    assign wrap_kr   = wrap_kc && kr_term;
    assign wrap_oc   = wrap_kr && oc_term;
    assign last_xfer = wrap_oc && orow_term;

    wrap_counter #(.WIDTH(DIMWIDTH)) u_kc (
        .WRAP_CNT_Clk(CONV_WINDOW_SEQ_Clk), .WRAP_CNT_Clr(CONV_WINDOW_SEQ_Clr),
        .WRAP_CNT_Load0(start_acc), .WRAP_CNT_En(xfer), .WRAP_CNT_Limit(k_lim),
        .WRAP_CNT_Count(kc_cnt), .WRAP_CNT_Term(kc_term));

    wrap_counter #(.WIDTH(DIMWIDTH)) u_kr (
        .WRAP_CNT_Clk(CONV_WINDOW_SEQ_Clk), .WRAP_CNT_Clr(CONV_WINDOW_SEQ_Clr),
        .WRAP_CNT_Load0(start_acc), .WRAP_CNT_En(wrap_kc), .WRAP_CNT_Limit(k_lim),
        .WRAP_CNT_Count(kr_cnt), .WRAP_CNT_Term(kr_term));

    wrap_counter #(.WIDTH(DIMWIDTH)) u_oc (
        .WRAP_CNT_Clk(CONV_WINDOW_SEQ_Clk), .WRAP_CNT_Clr(CONV_WINDOW_SEQ_Clr),
        .WRAP_CNT_Load0(start_acc), .WRAP_CNT_En(wrap_kr), .WRAP_CNT_Limit(oc_lim),
        .WRAP_CNT_Count(oc_cnt), .WRAP_CNT_Term(oc_term));

    wrap_counter #(.WIDTH(DIMWIDTH)) u_orow (
        .WRAP_CNT_Clk(CONV_WINDOW_SEQ_Clk), .WRAP_CNT_Clr(CONV_WINDOW_SEQ_Clr),
        .WRAP_CNT_Load0(start_acc), .WRAP_CNT_En(wrap_oc), .WRAP_CNT_Limit(orow_lim),
        .WRAP_CNT_Count(orow_cnt), .WRAP_CNT_Term(orow_term));

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (seq.CONV_WINDOW_SEQ_Start) state_d = CHECK;
            end
            CHECK:   state_d = cfg_bad ? DONE : RUN;
            RUN: begin
                valid = 1'b1;
                if (last_xfer) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CONV_WINDOW_SEQ_Clk or negedge CONV_WINDOW_SEQ_Clr) begin
        if (!CONV_WINDOW_SEQ_Clr) begin
            state_q     <= IDLE;
            w_q         <= '0;
            h_q         <= '0;
            k_q         <= '0;
            err_q       <= 1'b0;
            row_start_q <= '0;
            win_base_q  <= '0;
            tap_row_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                w_q         <= seq.CONV_WINDOW_SEQ_Width;
                h_q         <= seq.CONV_WINDOW_SEQ_Height;
                k_q         <= seq.CONV_WINDOW_SEQ_Ksize;
                err_q       <= 1'b0;
                row_start_q <= seq.CONV_WINDOW_SEQ_Base;
                win_base_q  <= seq.CONV_WINDOW_SEQ_Base;
                tap_row_q   <= seq.CONV_WINDOW_SEQ_Base;
            end
            if ((state_q == CHECK) && cfg_bad) err_q <= 1'b1;
            // row_start tracks Base + orow*W; win_base is the window's top-left tap
            if (wrap_oc) begin
                row_start_q <= row_start_q + w_ext;
                win_base_q  <= row_start_q + w_ext;
                tap_row_q   <= row_start_q + w_ext;
            end else if (wrap_kr) begin
                win_base_q  <= win_base_q + 1'b1;
                tap_row_q   <= win_base_q + 1'b1;
            end else if (wrap_kc) begin
                tap_row_q   <= tap_row_q + w_ext;
            end
        end
    end

    assign seq.CONV_WINDOW_SEQ_Addr       = tap_row_q + ADDRWIDTH'(kc_cnt);
    assign seq.CONV_WINDOW_SEQ_Valid      = valid;
    assign seq.CONV_WINDOW_SEQ_Win_Last   = valid && (kr_cnt == k_lim) && (kc_cnt == k_lim);
    assign seq.CONV_WINDOW_SEQ_Frame_Last = seq.CONV_WINDOW_SEQ_Win_Last &&
                                            (oc_cnt == oc_lim) && (orow_cnt == orow_lim);
    assign seq.CONV_WINDOW_SEQ_Busy       = busy;
    assign seq.CONV_WINDOW_SEQ_Done       = done;
    assign seq.CONV_WINDOW_SEQ_Err        = err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: nested-loop reference model of the window walk plus directed passes.
module tb_conv_window_sequencer;
    import cnn_seq_pkg::*;

    localparam int DW = 10;
    localparam int KW = 3;
    localparam int AW = 20;

    typedef struct {
        logic [AW-1:0] addr;
        bit            wl;
        bit            fl;
    } tap_t;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_sequencer_if #(.DIMWIDTH(DW), .KWIDTH(KW), .ADDRWIDTH(AW)) bus ();

    conv_window_sequencer #(.DIMWIDTH(DW), .KWIDTH(KW), .ADDRWIDTH(AW)) dut (
        .CONV_WINDOW_SEQ_Clk(clk),
        .CONV_WINDOW_SEQ_Clr(clr_n),
        .seq(bus.master)
    );

    logic [AW-1:0] addr;
    logic valid, wl, fl, busy, done, err, ready;
    assign addr  = bus.CONV_WINDOW_SEQ_Addr;
    assign valid = bus.CONV_WINDOW_SEQ_Valid;
    assign wl    = bus.CONV_WINDOW_SEQ_Win_Last;
    assign fl    = bus.CONV_WINDOW_SEQ_Frame_Last;
    assign busy  = bus.CONV_WINDOW_SEQ_Busy;
    assign done  = bus.CONV_WINDOW_SEQ_Done;
    assign err   = bus.CONV_WINDOW_SEQ_Err;
    assign ready = bus.CONV_WINDOW_SEQ_Ready;

    int errors = 0;
    int checks = 0;
    tap_t exp_q[$];
    logic [AW-1:0] xlog[$];
    bit wlog[$];
    bit flog[$];
    bit mon_en = 1'b0;
    bit rand_rdy = 1'b0;
    bit stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Reference walk: Addr = Base + (orow+kr)*W + oc + kc, raster window order
    function automatic void build_model(input int w, input int h, input int k, input logic [AW-1:0] b);
        exp_q.delete();
        for (int orow = 0; orow <= h - k; orow++)
            for (int oc = 0; oc <= w - k; oc++)
                for (int kr = 0; kr < k; kr++)
                    for (int kc = 0; kc < k; kc++) begin
                        tap_t t;
                        t.addr = b + AW'((orow + kr) * w + oc + kc);
                        t.wl   = (kr == k - 1) && (kc == k - 1);
                        t.fl   = t.wl && (oc == w - k) && (orow == h - k);
                        exp_q.push_back(t);
                    end
    endfunction

    // Stream monitor: every Valid cycle is compared against the model head
    always @(negedge clk) begin
        if (clr_n && mon_en) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    chk("extra_valid", 32'(valid), 32'd0);
                end else begin
                    chk("addr", 32'(addr), 32'(exp_q[0].addr));
                    chk("win_last", 32'(wl), 32'(exp_q[0].wl));
                    chk("frame_last", 32'(fl), 32'(exp_q[0].fl));
                    if (ready) begin
                        xlog.push_back(addr);
                        wlog.push_back(wl);
                        flog.push_back(fl);
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("flags_idle", {30'd0, wl, fl}, 32'd0);
            end
            if (stall_prev) chk("stall_hold", 32'(addr), 32'(stall_addr));
            stall_prev = valid && !ready;
            stall_addr = addr;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        bus.CONV_WINDOW_SEQ_Ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.CONV_WINDOW_SEQ_Ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic kick(input int w, input int h, input int k, input logic [AW-1:0] b);
        @(posedge clk);
        #1;
        bus.CONV_WINDOW_SEQ_Width  = DW'(w);
        bus.CONV_WINDOW_SEQ_Height = DW'(h);
        bus.CONV_WINDOW_SEQ_Ksize  = KW'(k);
        bus.CONV_WINDOW_SEQ_Base   = b;
        bus.CONV_WINDOW_SEQ_Start  = 1'b1;
        @(posedge clk);
        #1;
        bus.CONV_WINDOW_SEQ_Start  = 1'b0;
    endtask

    task automatic run_pass(input int w, input int h, input int k, input logic [AW-1:0] b, input bit rnd);
        bit bad, prev_fl, got;
        bad = (k == 0) || (k > w) || (k > h);
        if (bad) exp_q.delete(); else build_model(w, h, k, b);
        xlog.delete(); wlog.delete(); flog.delete();
        rand_rdy = rnd;
        mon_en = 1'b1;
        kick(w, h, k, b);
        @(negedge clk);
        chk("check_busy", 32'(busy), 32'd1);
        chk("check_valid", 32'(valid), 32'd0);
        chk("err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        if (bad) begin
            chk("bad_done", 32'(done), 32'd1);
            chk("bad_err", 32'(err), 32'd1);
            chk("bad_valid", 32'(valid), 32'd0);
            @(negedge clk);
            chk("bad_done_pulse", 32'(done), 32'd0);
            chk("bad_idle", 32'(busy), 32'd0);
            chk("bad_err_held", 32'(err), 32'd1);
        end else begin
            chk("first_valid", 32'(valid), 32'd1);
            chk("first_addr", 32'(addr), 32'(b));
            got = 1'b0;
            prev_fl = valid && ready && fl;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    break;
                end
                prev_fl = valid && ready && fl;
            end
            chk("done_seen", 32'(got), 32'd1);
            chk("done_after_last", 32'(prev_fl), 32'd1);
            chk("model_drained", 32'(exp_q.size()), 32'd0);
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        rand_rdy = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] first9 [9];
        int n;
        first9 = '{20'd0, 20'd1, 20'd2, 20'd5, 20'd6, 20'd7, 20'd10, 20'd11, 20'd12};
        bus.CONV_WINDOW_SEQ_Start  = 1'b0;
        bus.CONV_WINDOW_SEQ_Width  = '0;
        bus.CONV_WINDOW_SEQ_Height = '0;
        bus.CONV_WINDOW_SEQ_Ksize  = '0;
        bus.CONV_WINDOW_SEQ_Base   = '0;

        repeat (2) @(negedge clk);
        chk("rst_outputs", {25'd0, valid, wl, fl, busy, done, err, 1'b0}, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        @(posedge clk);
        #1 clr_n = 1'b1;

        // W=5 H=4 K=3, Ready always high
        run_pass(5, 4, 3, 20'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk("lit_addr9", 32'(xlog[i]), 32'(first9[i]));
            chk("lit_wl9", 32'(wlog[i]), 32'(i == 8));
        end
        chk("lit_count54", 32'(xlog.size()), 32'd54);
        chk("lit_last19", 32'(xlog[53]), 32'd19);
        chk("lit_fl_last", 32'(flog[53]), 32'd1);

        // K=1: every tap is its own window
        run_pass(2, 2, 1, 20'd100, 1'b0);
        chk("k1_count", 32'(xlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("k1_addr", 32'(xlog[i]), 32'(100 + i));
            chk("k1_wl", 32'(wlog[i]), 32'd1);
            chk("k1_fl", 32'(flog[i]), 32'(i == 3));
        end

        // Same pass under random backpressure
        run_pass(5, 4, 3, 20'd0, 1'b1);
        chk("rnd_count54", 32'(xlog.size()), 32'd54);
        chk("rnd_last19", 32'(xlog[53]), 32'd19);

        // Illegal kernel, then Err stays until the next legal start
        run_pass(5, 4, 6, 20'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("err_held_idle", 32'(err), 32'd1);
        run_pass(4, 4, 0, 20'd0, 1'b0);

        // K=W=H: single window; wrap past top of address space
        run_pass(3, 3, 3, 20'd7, 1'b0);
        chk("one_window", 32'(xlog.size()), 32'd9);
        run_pass(2, 2, 2, 20'hFFFFE, 1'b0);
        chk("wrap_addr2", 32'(xlog[2]), 32'd0);
        chk("wrap_addr3", 32'(xlog[3]), 32'd1);

        // Start during RUN with a different config is ignored
        fork
            begin
                repeat (12) @(posedge clk);
                #1;
                bus.CONV_WINDOW_SEQ_Width  = DW'(2);
                bus.CONV_WINDOW_SEQ_Height = DW'(2);
                bus.CONV_WINDOW_SEQ_Ksize  = KW'(1);
                bus.CONV_WINDOW_SEQ_Base   = 20'd500;
                bus.CONV_WINDOW_SEQ_Start  = 1'b1;
                @(posedge clk);
                #1 bus.CONV_WINDOW_SEQ_Start = 1'b0;
            end
        join_none
        run_pass(5, 4, 3, 20'd0, 1'b0);
        chk("restart_ignored", 32'(xlog.size()), 32'd54);
        repeat (3) @(negedge clk);
        chk("no_late_start", 32'(busy), 32'd0);

        // Reset after the 20th transfer aborts with no Done
        build_model(5, 4, 3, 20'd0);
        mon_en = 1'b1;
        kick(5, 4, 3, 20'd0);
        n = 0;
        for (int i = 0; i < 200 && n < 20; i++) begin
            @(negedge clk);
            if (valid && ready) n++;
        end
        chk("reached_20", 32'(n), 32'd20);
        @(posedge clk);
        #1 clr_n = 1'b0;
        mon_en = 1'b0;
        #1;
        chk("abort_outputs", {25'd0, valid, wl, fl, busy, done, err, 1'b0}, 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk);
        #1 clr_n = 1'b1;
        exp_q.delete();
        run_pass(5, 4, 3, 20'd0, 1'b0);
        chk("post_rst_count", 32'(xlog.size()), 32'd54);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Generates the feature-map read-address stream for one KxK convolution pass, stride 1, no padding.
- For each output pixel it walks the KxK input window in raster order.
- Sits between the layer controller (start/config) and the feature-map memory read port (valid/ready address stream).
- Replaces ad-hoc chaining of enable-gated offset counters with one sequenced, back-pressurable address source.

Parameters:
- DIMWIDTH, 10, width of image width/height and window/pixel indices.
- KWIDTH, 3, width of kernel-size input (K up to 7).
- ADDRWIDTH, 20, width of base and output address.

Ports:
- CONV_WINDOW_SEQ_Clk  in  1  clock, rising edge.
- CONV_WINDOW_SEQ_Clr  in  1  reset, asynchronous, active-low.
- CONV_WINDOW_SEQ_Start  in  1  one-cycle start request.
- CONV_WINDOW_SEQ_Width  in  DIMWIDTH  input image width W.
- CONV_WINDOW_SEQ_Height  in  DIMWIDTH  input image height H.
- CONV_WINDOW_SEQ_Ksize  in  KWIDTH  kernel size K.
- CONV_WINDOW_SEQ_Base  in  ADDRWIDTH  base address of the image.
- CONV_WINDOW_SEQ_Ready  in  1  memory accepts address.
- CONV_WINDOW_SEQ_Addr  out  ADDRWIDTH  read address.
- CONV_WINDOW_SEQ_Valid  out  1  Addr valid.
- CONV_WINDOW_SEQ_Win_Last  out  1  Addr is the last tap of its window.
- CONV_WINDOW_SEQ_Frame_Last  out  1  Addr is the last tap of the last window.
- CONV_WINDOW_SEQ_Busy  out  1  pass in progress.
- CONV_WINDOW_SEQ_Done  out  1  one-cycle pulse at pass end.
- CONV_WINDOW_SEQ_Err  out  1  last start had illegal config; held until next accepted start.

Behaviour:
- Reset (async, Clr=0): FSM=IDLE; all outputs 0; all index/accumulator registers 0.
- FSM states: IDLE, CHECK, RUN, DONE.
  - IDLE: Start=1 latches W, H, K, Base, clears Err, moves to CHECK. Start in any other state is ignored.
  - CHECK (1 cycle): if K=0, K>W or K>H, set Err=1 and go to DONE. Otherwise go to RUN, with Valid=1 and Addr=Base on entry.
  - RUN: a transfer occurs when Valid&Ready. On the transfer of the Frame_Last address, Valid drops next cycle and the FSM goes to DONE.
  - DONE (1 cycle): Done=1, then IDLE.
- Busy=1 in CHECK, RUN and DONE.
- Timing: first Valid appears 2 cycles after Start is sampled. Legal config: Done rises 1 cycle after the final transfer. Illegal config: Done rises 2 cycles after Start.
- Handshake: while Valid=1 and Ready=0, Addr, Win_Last and Frame_Last hold stable. Valid never drops in RUN until the final transfer. Throughput is one address per cycle at Ready=1.
- Iteration order, fastest first: kc 0..K-1, kr 0..K-1, oc 0..W-K, orow 0..H-K.
- Addr = Base + (orow+kr)*W + oc + kc, modulo 2^ADDRWIDTH. No multiplier: kept incrementally.
  - win_base += 1 per oc step.
  - At oc wrap, win_base = row_start + W, where row_start tracks orow*W.
  - tap_row += W per kr step.
  - Addr = tap_row + kc.
- Win_Last = (kr=K-1 && kc=K-1). Frame_Last = Win_Last && oc=W-K && orow=H-K.
- Addresses per pass = K*K*(W-K+1)*(H-K+1).
- Boundaries:
  - K=W=H gives exactly one window.
  - K=1 makes every address Win_Last.
  - Addresses wrap silently past 2^ADDRWIDTH-1.
  - Config inputs are don't-care outside IDLE.
  - Reset mid-pass aborts immediately with no Done pulse.

Decomposition:
- Shared package cnn_seq_pkg holds:
  - FSM state encoding (2-bit localparams: IDLE, CHECK, RUN, DONE).
  - Default DIMWIDTH, KWIDTH and ADDRWIDTH constants.
- One natural sub-module, wrap_counter.
  - Function: parametric-width counter with synchronous load-0, enable, limit input and terminal flag (count==limit).
  - Instances: four, for kc, kr, oc and orow.
  - Chaining: each enable is the previous terminal flag AND the transfer.
- The address accumulators stay in the top module.

Test Plan:
- W=5, H=4, K=3, Base=0, Ready=1 -> first 9 Addr: 0,1,2,5,6,7,10,11,12, with Win_Last only on 12. 54 transfers total; last Addr=19 with Frame_Last=1; Done 1 cycle later.
- W=2, H=2, K=1, Base=100 -> Addr 100,101,102,103, each with Win_Last=1; Frame_Last on 103.
- First case with Ready toggled pseudo-randomly -> identical address sequence; Addr stable whenever Valid&!Ready; no lost or duplicated transfers.
- Start with W=5, H=4, K=6 -> Err=1, Valid never asserted, Done 2 cycles after Start, Err held until the next legal Start clears it.
- Start pulsed again during RUN with different config -> ignored; original 54-address sequence completes unchanged.
- Clr asserted after the 20th transfer -> all outputs 0 immediately, FSM IDLE, no Done. A new Start restarts from Addr=Base.
